// File: rtl/operand_bypass.sv
// ---------------------------------------------------------------------------
// operand_bypass
//
// Operand forwarding and load-use interlock for the execute stage. Each
// source operand is resolved against the in-flight writes of every
// downstream stage and lane. It is then resolved against a short history of
// writes that retired while the consumer was stalled. If nothing matches,
// the operand falls back to the register-file read data. A load that is
// still in flight in an early stage raises a combinational stall.
//
// Ports
//   clk           : clock
//   rst           : synchronous active-high reset
//   clk_en        : global advance enable, all state holds when low
//   flush         : exception/rfe in writeback, kills stall and history
//   src_valid     : consumer instruction is not a bubble
//   src_used      : per-source "operand actually read"
//   src_idx       : packed source register indices, source j at j*REG_BITS
//   rf_data       : packed register-file read data, source j at j*WIDTH
//   stg_valid     : per-stage non-bubble flag
//   stg_load      : per-stage "instruction is a load" flag
//   stg_tgt       : packed write targets, slot (s,l) at (s*LANES+l)*REG_BITS
//   stg_data      : packed write data, slot (s,l) at (s*LANES+l)*WIDTH
//   operand       : resolved operands (combinational)
//   stall         : load-use interlock (combinational)
//   stall_cycles  : saturating count of stalled clk_en edges
//   hist_overflow : sticky, a valid history entry was dropped
// ---------------------------------------------------------------------------
module operand_bypass #(
   parameter int WIDTH       = 32,
   parameter int REG_BITS    = 5,
   parameter int SRCS        = 2,
   parameter int STAGES      = 4,
   parameter int LANES       = 2,
   parameter int LOAD_STAGES = 3,
   parameter int HIST        = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clk_en,
   input  logic                             flush,
   input  logic                             src_valid,
   input  logic [SRCS-1:0]                  src_used,
   input  logic [SRCS*REG_BITS-1:0]         src_idx,
   input  logic [SRCS*WIDTH-1:0]            rf_data,
   input  logic [STAGES-1:0]                stg_valid,
   input  logic [STAGES-1:0]                stg_load,
   input  logic [STAGES*LANES*REG_BITS-1:0] stg_tgt,
   input  logic [STAGES*LANES*WIDTH-1:0]    stg_data,
   output logic [SRCS*WIDTH-1:0]            operand,
   output logic                             stall,
   output logic [15:0]                      stall_cycles,
   output logic                             hist_overflow
);

   // History of retired writeback data. Entry 0 is the newest.
   logic [LANES-1:0]                r_histValid [HIST];
   logic [LANES-1:0][REG_BITS-1:0]  r_histTgt   [HIST];
   logic [LANES-1:0][WIDTH-1:0]     r_histData  [HIST];
   logic [15:0]                     r_stallCycles;
   logic                            r_histOverflow;

   logic [STAGES-1:0][LANES-1:0]    w_match [SRCS];
   logic                            w_hazard;

   // Per-source, per-slot match against in-flight writes. Register 0 is
   // never forwarded, so a zero source index matches nothing.
   always_comb begin
      w_match = '{default: '0};
      for (int j = 0; j < SRCS; j++) begin
         for (int s = 0; s < STAGES; s++) begin
            for (int l = 0; l < LANES; l++) begin
               w_match[j][s][l] = stg_valid[s]
                  && (src_idx[j*REG_BITS +: REG_BITS] != '0)
                  && (stg_tgt[(s*LANES+l)*REG_BITS +: REG_BITS] == src_idx[j*REG_BITS +: REG_BITS]);
            end
         end
      end
   end

   // Operand selection walks the sources from lowest to highest priority,
   // so the last assignment that hits is the winner. The order is register
   // file, then oldest history, then newest history, then writeback stage,
   // then the youngest stage. Within a stage or entry, lane 0 is applied
   // last so that it outranks the higher lanes.
   always_comb begin
      operand = rf_data;
      for (int j = 0; j < SRCS; j++) begin
         for (int h = HIST-1; h >= 0; h--) begin
            for (int l = LANES-1; l >= 0; l--) begin
               if (r_histValid[h][l] && (r_histTgt[h][l] != '0)
                   && (r_histTgt[h][l] == src_idx[j*REG_BITS +: REG_BITS])) begin
                  operand[j*WIDTH +: WIDTH] = r_histData[h][l];
               end
            end
         end
         for (int s = STAGES-1; s >= 0; s--) begin
            for (int l = LANES-1; l >= 0; l--) begin
               if (w_match[j][s][l]) begin
                  operand[j*WIDTH +: WIDTH] = stg_data[(s*LANES+l)*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   // A load in one of the early stages has no data yet. Any source that is
   // actually read and matches such a load must wait. Loads that reach the
   // later stages forward normally.
   always_comb begin
      w_hazard = 1'b0;
      for (int j = 0; j < SRCS; j++) begin
         for (int s = 0; s < STAGES; s++) begin
            if ((s < LOAD_STAGES) && src_used[j] && stg_load[s] && (|w_match[j][s])) begin
               w_hazard = 1'b1;
            end
         end
      end
   end

   assign stall = !rst && !flush && src_valid && w_hazard;

   // History, stall counter and overflow flag. While the consumer is stalled,
   // each advancing edge captures the writeback stage into entry 0 and ages
   // the older entries. Any non-stalled advance retires the consumer, so the
   // history is emptied. A flush also takes this path because it forces
   // stall low.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int h = 0; h < HIST; h++) begin
            r_histValid[h] <= '0;
         end
         r_stallCycles  <= '0;
         r_histOverflow <= 1'b0;
      end else if (clk_en) begin
         if (stall) begin
            for (int h = HIST-1; h > 0; h--) begin
               r_histValid[h] <= r_histValid[h-1];
               r_histTgt[h]   <= r_histTgt[h-1];
               r_histData[h]  <= r_histData[h-1];
            end
            for (int l = 0; l < LANES; l++) begin
               r_histValid[0][l] <= stg_valid[STAGES-1];
               r_histTgt[0][l]   <= stg_tgt[((STAGES-1)*LANES+l)*REG_BITS +: REG_BITS];
               r_histData[0][l]  <= stg_data[((STAGES-1)*LANES+l)*WIDTH +: WIDTH];
            end
            if (|r_histValid[HIST-1]) begin
               r_histOverflow <= 1'b1;
            end
            if (r_stallCycles != 16'hFFFF) begin
               r_stallCycles <= r_stallCycles + 16'd1;
            end
         end else begin
            for (int h = 0; h < HIST; h++) begin
               r_histValid[h] <= '0;
            end
         end
      end
   end

   assign stall_cycles  = r_stallCycles;
   assign hist_overflow = r_histOverflow;

endmodule
